// File: rtl/acorn128_ad_encrypt_finalize_if.sv
// ACORN-128 post-init datapath bus: start handshake, block inputs and results.
interface acorn128_ad_encrypt_finalize_if;
    logic         start_in;
    logic [292:0] state_in;
    logic [127:0] ad_in;
    logic [127:0] plaintext_in;
    logic [127:0] ciphertext_out;
    logic [127:0] tag_out;
    logic [292:0] state_out;
    logic         busy_out;
    logic         ready_out;

    modport master (
        output start_in, state_in, ad_in, plaintext_in,
        input  ciphertext_out, tag_out, state_out, busy_out, ready_out
    );

    modport slave (
        input  start_in, state_in, ad_in, plaintext_in,
        output ciphertext_out, tag_out, state_out, busy_out, ready_out
    );
endinterface

// File: rtl/acorn128_ad_encrypt_finalize.sv
// ACORN-128 v3 AD absorption, single-block encryption and tag generation,
// one state-update step per clock.
module acorn128_ad_encrypt_finalize (
    input  logic clk,
    input  logic rst,
    acorn128_ad_encrypt_finalize_if.slave bus
);
    typedef enum logic [2:0] {IDLE, AD, ENC, FIN, DONE} state_e;

    state_e       st_q, st_d;
    logic [9:0]   cnt_q, cnt_d;
    logic [292:0] s_q, s_d;
    logic [127:0] ad_q, ad_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] tag_q, tag_d;

    logic         m, ca, cb, ks, f;
    logic [292:0] t;
    logic         run;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= IDLE;
            cnt_q <= '0;
            s_q   <= '0;
            ad_q  <= '0;
            pt_q  <= '0;
            ct_q  <= '0;
            tag_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            s_q   <= s_d;
            ad_q  <= ad_d;
            pt_q  <= pt_d;
            ct_q  <= ct_d;
            tag_q <= tag_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE, DONE: if (bus.start_in) st_d = AD;
            AD:         if (cnt_q == 10'd383) st_d = ENC;
            ENC:        if (cnt_q == 10'd383) st_d = FIN;
            FIN:        if (cnt_q == 10'd767) st_d = DONE;
            default:    st_d = IDLE;
        endcase
    end

    // Message/control bits; AD and ENC share the same padding tail.
    always_comb begin
        m  = 1'b0;
        ca = 1'b1;
        cb = 1'b1;
        unique case (1'b1)
            (st_q == AD) || (st_q == ENC): begin
                if (cnt_q < 10'd128)
                    m = (st_q == AD) ? ad_q[cnt_q[6:0]] : pt_q[cnt_q[6:0]];
                else
                    m = (cnt_q == 10'd128);
                ca = (cnt_q < 10'd256);
                cb = (st_q == AD);
            end
            default: ;
        endcase
    end

    always_comb begin
        t = s_q;
        t[289] = t[289] ^ t[235] ^ t[230];
        t[230] = t[230] ^ t[196] ^ t[193];
        t[193] = t[193] ^ t[160] ^ t[154];
        t[154] = t[154] ^ t[111] ^ t[107];
        t[107] = t[107] ^ t[66]  ^ t[61];
        t[61]  = t[61]  ^ t[23]  ^ t[0];
        ks = t[12] ^ t[154] ^ maj(t[235], t[61], t[193])
           ^ ch(t[230], t[111], t[66]);
        f  = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160])
           ^ (ca & t[196]) ^ (cb & ks) ^ m;
    end

    assign run = (st_q == AD) || (st_q == ENC) || (st_q == FIN);

    always_comb begin
        cnt_d = cnt_q;
        s_d   = s_q;
        ad_d  = ad_q;
        pt_d  = pt_q;
        ct_d  = ct_q;
        tag_d = tag_q;
        if (run) begin
            s_d   = {f, t[292:1]};
            cnt_d = (st_d != st_q) ? 10'd0 : cnt_q + 10'd1;
            if (st_q == ENC && cnt_q < 10'd128)
                ct_d[cnt_q[6:0]] = pt_q[cnt_q[6:0]] ^ ks;
            // 640 is a multiple of 128, so the low bits index the tag
            if (st_q == FIN && cnt_q >= 10'd640)
                tag_d[cnt_q[6:0]] = ks;
        end else if (bus.start_in) begin
            cnt_d = '0;
            s_d   = bus.state_in;
            ad_d  = bus.ad_in;
            pt_d  = bus.plaintext_in;
        end
    end

    always_comb begin
        bus.busy_out       = run;
        bus.ready_out      = (st_q == DONE);
        bus.ciphertext_out = ct_q;
        bus.tag_out        = tag_q;
        bus.state_out      = s_q;
    end
endmodule

// File: tb/tb_acorn128_ad_encrypt_finalize.sv
// Randomized self-checking bench for the ACORN-128 post-init datapath
// against a step-by-step software model of the cipher schedule.
module tb_acorn128_ad_encrypt_finalize;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    acorn128_ad_encrypt_finalize_if bus ();

    acorn128_ad_encrypt_finalize dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [292:0] got,
                       input logic [292:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit fmaj(input bit x, input bit y, input bit z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // One ACORN state update on an unpacked bit array.
    function automatic void ref_step(input bit si[293], input bit m,
                                     input bit ca, input bit cb,
                                     output bit so[293], output bit ks);
        bit s[293];
        bit fb;
        s = si;
        s[289] ^= s[235] ^ s[230];
        s[230] ^= s[196] ^ s[193];
        s[193] ^= s[160] ^ s[154];
        s[154] ^= s[111] ^ s[107];
        s[107] ^= s[66] ^ s[61];
        s[61]  ^= s[23] ^ s[0];
        ks = s[12] ^ s[154] ^ fmaj(s[235], s[61], s[193])
           ^ ((s[230] & s[111]) ^ (!s[230] & s[66]));
        fb = s[0] ^ !s[107] ^ fmaj(s[244], s[23], s[160])
           ^ (ca & s[196]) ^ (cb & ks) ^ m;
        for (int j = 0; j < 292; j++) so[j] = s[j + 1];
        so[292] = fb;
    endfunction

    function automatic void ref_run(input logic [292:0] st,
                                    input logic [127:0] ad,
                                    input logic [127:0] pt,
                                    output logic [127:0] ct,
                                    output logic [127:0] tag,
                                    output logic [292:0] fin);
        bit s[293];
        bit ns[293];
        bit m, ca, cb, ks;
        int i;
        for (int j = 0; j < 293; j++) s[j] = st[j];
        ct = '0;
        tag = '0;
        for (int k = 0; k < 1536; k++) begin
            if (k < 768) begin
                i  = (k < 384) ? k : k - 384;
                cb = (k < 384);
                ca = (i < 256);
                if (i < 128) m = (k < 384) ? ad[i] : pt[i];
                else m = (i == 128);
            end else begin
                i = k - 768;
                m = 0; ca = 1; cb = 1;
            end
            ref_step(s, m, ca, cb, ns, ks);
            s = ns;
            if (k >= 384 && k < 512) ct[i] = pt[i] ^ ks;
            if (k >= 768 + 640) tag[i - 640] = ks;
        end
        for (int j = 0; j < 293; j++) fin[j] = s[j];
    endfunction

    // ACORN-128 v3 initialization with key = 0 and IV = 0.
    function automatic logic [292:0] ref_init();
        bit s[293];
        bit ns[293];
        bit ks;
        logic [292:0] r;
        for (int j = 0; j < 293; j++) s[j] = 0;
        for (int k = 0; k < 1792; k++) begin
            ref_step(s, (k == 256), 1'b1, 1'b1, ns, ks);
            s = ns;
        end
        for (int j = 0; j < 293; j++) r[j] = s[j];
        return r;
    endfunction

    function automatic logic [292:0] rnd293();
        logic [292:0] r;
        for (int j = 0; j < 293; j++) r[j] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic do_run(input logic [292:0] st, input logic [127:0] ad,
                          input logic [127:0] pt, input int poke,
                          input string nm);
        logic [127:0] ect, etag;
        logic [292:0] est;
        int n;
        bit done;
        ref_run(st, ad, pt, ect, etag, est);
        bus.state_in = st;
        bus.ad_in = ad;
        bus.plaintext_in = pt;
        bus.start_in = 1'b1;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        bus.state_in = ~st;
        bus.ad_in = ~ad;
        bus.plaintext_in = ~pt;
        n = 0;
        done = 0;
        while (!done && n < 1600) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                chk({nm, "_busy1"}, 293'(bus.busy_out), 293'(1));
                chk({nm, "_rdy1"}, 293'(bus.ready_out), 293'(0));
            end
            if (n == 512) chk({nm, "_ctmid"}, 293'(bus.ciphertext_out), 293'(ect));
            if (n == poke) begin
                bus.start_in = 1'b1;
                bus.ad_in = rnd128();
                @(posedge clk);
                #1;
                n++;
                bus.start_in = 1'b0;
            end
            if (bus.ready_out) done = 1;
        end
        chk({nm, "_lat"}, 293'(n), 293'(1536));
        chk({nm, "_busy"}, 293'(bus.busy_out), 293'(0));
        chk({nm, "_ct"}, 293'(bus.ciphertext_out), 293'(ect));
        chk({nm, "_tag"}, 293'(bus.tag_out), 293'(etag));
        chk({nm, "_state"}, bus.state_out, est);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_hold_rdy"}, 293'(bus.ready_out), 293'(1));
        chk({nm, "_hold_tag"}, 293'(bus.tag_out), 293'(etag));
    endtask

    logic [292:0] st_r;
    logic [127:0] ad_r;

    initial begin
        rst = 1'b1;
        bus.start_in = 1'b1;
        bus.state_in = rnd293();
        bus.ad_in = '0;
        bus.plaintext_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ct", 293'(bus.ciphertext_out), '0);
        chk("rst_tag", 293'(bus.tag_out), '0);
        chk("rst_state", bus.state_out, '0);
        chk("rst_busy", 293'(bus.busy_out), '0);
        chk("rst_rdy", 293'(bus.ready_out), '0);
        rst = 1'b0;
        bus.start_in = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_start_ign", 293'(bus.busy_out), '0);

        do_run('0, '0, '0, 0, "zero");
        do_run(ref_init(), 128'h0123456789abcdef0123456789abcdef,
               '1, 0, "kat");

        st_r = rnd293();
        ad_r = rnd128();
        do_run(st_r, ad_r, rnd128(), 500, "poke");
        do_run(st_r, ad_r, rnd128(), 0, "b2b");

        bus.state_in = rnd293();
        bus.ad_in = rnd128();
        bus.plaintext_in = rnd128();
        bus.start_in = 1'b1;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        repeat (900) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_state", bus.state_out, '0);
        chk("mid_rst_tag", 293'(bus.tag_out), '0);
        chk("mid_rst_ct", 293'(bus.ciphertext_out), '0);
        chk("mid_rst_busy", 293'(bus.busy_out), '0);
        chk("mid_rst_rdy", 293'(bus.ready_out), '0);
        do_run(rnd293(), rnd128(), rnd128(), 0, "rerun");

        for (int r = 0; r < 2; r++)
            do_run(rnd293(), rnd128(), rnd128(), 0, $sformatf("rnd%0d", r));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/acorn128_ad_encrypt_finalize.md
# acorn128_ad_encrypt_finalize

Post-initialization datapath of the ACORN-128 (v3) authenticated cipher. It starts from the 293-bit state produced by the initialization stage. It then absorbs one 128-bit associated-data block, encrypts one 128-bit plaintext block and generates the 128-bit tag, at one state-update step per clock. It sits between the initialization block and the top-level controller, which only pulses `start_in` and waits for `ready_out`.

## Interface
- No parameters; AD length and plaintext length are fixed at 128 bits each.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `start_in` in 1: one-cycle start request, accepted only in IDLE.
- `state_in` in 293: initialized ACORN state, S0 = bit 0.
- `ad_in` in 128: associated data; bit i is absorbed at step i.
- `plaintext_in` in 128: plaintext; bit i is encrypted at step i.
- `ciphertext_out` out 128: ciphertext; bit i = plaintext bit i XOR keystream at encryption step i.
- `tag_out` out 128: tag; bit j = keystream of finalization step 640+j.
- `state_out` out 293: current internal state.
- `busy_out` out 1: high while processing.
- `ready_out` out 1: high when results are valid.

## Operation
- **Inputs:** `state_in`, `ad_in` and `plaintext_in` are captured into internal registers on the accepted start. Changes after acceptance have no effect.
- **Step function.** Each step takes message bit m and control bits ca, cb. Update in this order:
  - S289 ^= S235^S230
  - S230 ^= S196^S193
  - S193 ^= S160^S154
  - S154 ^= S111^S107
  - S107 ^= S66^S61
  - S61 ^= S23^S0
- **Keystream, computed on the updated values:**
  - ks = S12 ^ S154 ^ maj(S235,S61,S193) ^ ch(S230,S111,S66)
  - maj(x,y,z) = xy^xz^yz
  - ch(x,y,z) = xy^(~x)z
- **Feedback and shift:**
  - f = S0 ^ ~S107 ^ maj(S244,S23,S160) ^ (ca&S196) ^ (cb&ks) ^ m
  - Shift S[j] <= S[j+1] for j = 0..291, then S292 <= f.
- **FSM states:** IDLE, AD, ENC, FIN, DONE. A 10-bit step counter restarts at 0 on every phase entry.
- **AD phase, 384 steps:**
  - Steps 0–127: m = ad_in[i], ca = 1, cb = 1.
  - Steps 128–383: m = 1 at step 128 and 0 otherwise; ca = 1 for steps 128–255 and 0 for steps 256–383; cb = 1.
- **ENC phase, 384 steps:**
  - Steps 0–127: m = plaintext_in[i], ca = 1, cb = 0; ciphertext bit i = plaintext_in[i] ^ ks.
  - Steps 128–383: same padding pattern as AD (m = 1 at step 128 only; ca = 1 for steps 128–255), with cb = 0.
- **FIN phase, 768 steps:** m = 0, ca = 1, cb = 1. The ks of steps 640–767 is written into `tag_out[0..127]`.
- **DONE:** state frozen. `ready_out` = 1 and outputs hold until the next accepted `start_in`, which clears `ready_out` and enters AD.
- **Start rules:** `start_in` in AD, ENC or FIN is ignored. `start_in` in DONE restarts the block with freshly captured inputs.
- This block performs encryption only.

## Timing
- **Reset:**
  - Reset values: `ciphertext_out`, `tag_out`, `state_out` = 0; `busy_out` = 0; `ready_out` = 0; FSM = IDLE; counter = 0.
  - `rst` asserted mid-operation aborts the run at the next edge and returns to these values.
- **Start acceptance:** `start_in` high at edge T is accepted in IDLE or DONE. `busy_out` = 1 from T+1.
- **Step schedule:** step k of the 1536-step sequence (AD 0–383, ENC 384–767, FIN 768–1535) is applied at edge T+1+k.
- **Completion:** the last step is applied at edge T+1536. At that edge `busy_out` falls, `ready_out` rises and `tag_out` is complete.
- **Latency:** 1536 cycles from start to ready.
- **Ciphertext:** bit i of `ciphertext_out` is written at the edge of ENC step i. The full ciphertext is stable from ENC step 127 onward.
- **Phase boundaries:** no idle cycles between phases.

## Test plan
- **Reset:** assert `rst` for 2 cycles -> all outputs 0, `busy_out` = 0, `ready_out` = 0; `start_in` held during reset is ignored.
- **Latency:** pulse `start_in` with `state_in` = 0, `ad_in` = 0, `plaintext_in` = 0 -> `ready_out` rises exactly 1536 cycles after the start edge and stays high.
- **Known answer:** `state_in` from a bit-accurate software ACORN-128 v3 model after init with key = 0, IV = 0; `ad_in` = 128'h0123…cdef; `plaintext_in` = 128'hFFFF…FFFF -> `ciphertext_out`, `tag_out` and final `state_out` match the model exactly.
- **Start while busy:** pulse `start_in` at cycle 500 with different `ad_in` -> results identical to an undisturbed run.
- **Reset mid-operation:** assert `rst` at cycle 900 (during FIN), then restart -> outputs cleared, then the correct tag after 1536 cycles.
- **Back-to-back runs:** start again from DONE with new `plaintext_in` -> `ready_out` drops on the next cycle and a new correct result arrives 1536 cycles later.
